// File: rtl/cache_fill_ctrl_pkg.sv
// cache_pkg: shared types and geometry constants for the cache miss-fill
// sequencer (4-way, 32-set, 8-word-per-block data array).
//   fill_state_t  : sequencer state (IDLE, FILL, DONE)
//   WORDS/SETS/WAYS, OFF_BITS, SET_LSB/SET_MSB : array geometry and address split
//   OWN_I / OWN_D : encoding of the requester that owns the current fill
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam int WORDS    = 8;
    localparam int SETS     = 32;
    localparam int WAYS     = 4;
    localparam int OFF_BITS = 4;
    localparam int SET_LSB  = 4;
    localparam int SET_MSB  = 8;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_if: memory read port plus data-array write port of the fill
// sequencer.
//   mem_en/mem_addr      : read strobe and word address (sequencer -> memory)
//   mem_valid/mem_data   : in-order read return (memory -> sequencer)
//   arr_din              : write data to the array
//   arr_write            : one-hot way write, 0 = no write
//   arr_block_en         : one-hot set enable
//   arr_word_en          : one-hot word enable
// modport master = sequencer side, modport slave = memory/array side.
interface cache_fill_if;
    import cache_pkg::*;

    logic              mem_en;
    logic [15:0]       mem_addr;
    logic              mem_valid;
    logic [15:0]       mem_data;
    logic [15:0]       arr_din;
    logic [WAYS-1:0]   arr_write;
    logic [SETS-1:0]   arr_block_en;
    logic [WORDS-1:0]  arr_word_en;

    modport master (
        output mem_en, mem_addr, arr_din, arr_write, arr_block_en, arr_word_en,
        input  mem_valid, mem_data
    );

    modport slave (
        input  mem_en, mem_addr, arr_din, arr_write, arr_block_en, arr_word_en,
        output mem_valid, mem_data
    );

endinterface

// File: rtl/cache_fill_ctrl_arb.sv
// fill_arb: two-input grant logic for the I-side and D-side miss requesters.
// Build option CACHE_FILL_RR_EN:
//   undefined : fixed priority, D wins a tie; purely combinational.
//   defined   : round-robin on ties via a 1-bit "D won last tie" pointer that
//               resets to "I served last", so D wins the first tie.
// Ports: i_req, d_req (requests), gnt_valid (someone is requesting),
//        gnt_owner (OWN_I/OWN_D); with round-robin also clk, rst (async,
//        active-low) and take (grant accepted this cycle).
module fill_arb
    import cache_pkg::*;
(
`ifdef CACHE_FILL_RR_EN
    input  logic clk,
    input  logic rst,
    input  logic take,
`endif
    input  logic i_req,
    input  logic d_req,
    output logic gnt_valid,
    output logic gnt_owner
);

    assign gnt_valid = i_req | d_req;

`ifdef CACHE_FILL_RR_EN
    logic last_d;

    always_comb begin
        gnt_owner = OWN_D;
        if (i_req && d_req) begin
            gnt_owner = last_d ? OWN_I : OWN_D;
        end else if (i_req) begin
            gnt_owner = OWN_I;
        end
    end

    // Only contested grants move the pointer: a lone requester being served
    // must not cost it the next tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d <= 1'b0;
        end else if (take && i_req && d_req) begin
            last_d <= gnt_owner;
        end
    end
`else
    assign gnt_owner = d_req ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: miss-fill sequencer for the 4-way, 32-set, 8-word cache
// data array. Arbitrates I/D miss requests, issues 8 pipelined word reads for
// the missing block and steers each returned word into the array.
// Build option CACHE_FILL_RR_EN selects round-robin arbitration (see fill_arb).
//
// State table:
//   IDLE | no fill; grant a pending request and latch owner/base/set/way
//   FILL | issue 8 reads (mem_en), write each returned word into the array
//   DONE | one cycle; pulse the owner's done, then back to IDLE
//
// Ports:
//   clk, rst (async, active-low)
//   i_req/i_addr/i_way, d_req/d_addr/d_way : miss requesters (level req)
//   i_done, d_done : one-cycle completion pulses
//   busy           : fill in progress (FILL or DONE)
//   bus            : memory read port + array write port (cache_fill_if.master)
module cache_fill_ctrl
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_req,
    input  logic [15:0]        i_addr,
    input  logic [WAYS-1:0]    i_way,
    input  logic               d_req,
    input  logic [15:0]        d_addr,
    input  logic [WAYS-1:0]    d_way,
    output logic               i_done,
    output logic               d_done,
    output logic               busy,
    cache_fill_if.master       bus
);

    fill_state_t       state;
    logic              owner;
    logic [4:0]        set_q;
    logic [WAYS-1:0]   way_q;
    logic [2:0]        issue_cnt;
    logic [2:0]        recv_cnt;
    logic              mem_en_q;
    logic [15:0]       mem_addr_q;
    logic              i_done_q;
    logic              d_done_q;
    logic              busy_q;

    logic              gnt_valid;
    logic              gnt_owner;
    logic [15:0]       sel_addr;
    logic [WAYS-1:0]   sel_way;
    logic              wr_fire;

    // Byte-offset bits select nothing: a fill always covers the whole block.
    logic unused_offset;
    assign unused_offset = ^sel_addr[OFF_BITS-1:0];

    fill_arb u_arb (
`ifdef CACHE_FILL_RR_EN
        .clk       (clk),
        .rst       (rst),
        .take      (state == IDLE),
`endif
        .i_req     (i_req),
        .d_req     (d_req),
        .gnt_valid (gnt_valid),
        .gnt_owner (gnt_owner)
    );

    assign sel_addr = (gnt_owner == OWN_D) ? d_addr : i_addr;
    assign sel_way  = (gnt_owner == OWN_D) ? d_way  : i_way;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= OWN_I;
            set_q      <= '0;
            way_q      <= '0;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
            mem_en_q   <= 1'b0;
            mem_addr_q <= '0;
            i_done_q   <= 1'b0;
            d_done_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        state      <= FILL;
                        owner      <= gnt_owner;
                        set_q      <= sel_addr[SET_MSB:SET_LSB];
                        way_q      <= sel_way;
                        issue_cnt  <= '0;
                        recv_cnt   <= '0;
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= {sel_addr[15:OFF_BITS], {OFF_BITS{1'b0}}};
                        busy_q     <= 1'b1;
                    end
                end
                FILL: begin
                    // mem_addr tracks base + 2*issue_cnt by stepping 2 per issue.
                    if (mem_en_q) begin
                        issue_cnt <= issue_cnt + 3'd1;
                        if (issue_cnt == 3'(WORDS - 1)) begin
                            mem_en_q   <= 1'b0;
                            mem_addr_q <= '0;
                        end else begin
                            mem_addr_q <= mem_addr_q + 16'd2;
                        end
                    end
                    if (bus.mem_valid) begin
                        recv_cnt <= recv_cnt + 3'd1;
                        if (recv_cnt == 3'(WORDS - 1)) begin
                            state <= DONE;
                            if (owner == OWN_D) begin
                                d_done_q <= 1'b1;
                            end else begin
                                i_done_q <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Array steering is combinational from mem_valid so each word is written
    // in the cycle it returns; gating by FILL drops stray returns outside a fill.
    assign wr_fire          = (state == FILL) && bus.mem_valid;
    assign bus.arr_din      = wr_fire ? bus.mem_data : '0;
    assign bus.arr_write    = wr_fire ? way_q : '0;
    assign bus.arr_block_en = wr_fire ? (SETS'(1) << set_q) : '0;
    assign bus.arr_word_en  = wr_fire ? (WORDS'(1) << recv_cnt) : '0;

    assign bus.mem_en   = mem_en_q;
    assign bus.mem_addr = mem_addr_q;
    assign i_done       = i_done_q;
    assign d_done       = d_done_q;
    assign busy         = busy_q;

endmodule
